// File: rtl/iob_eth_tx_if.sv
// Frame-buffer / MII transmit bundle for iob_eth_tx.
// slave = transmitter side, master = host + TX buffer RAM + PHY side.
interface iob_eth_tx_if;
  logic        send;
  logic [10:0] nbytes;
  logic        ready;
  logic [10:0] addr;
  logic [7:0]  data;
  logic        TX_EN;
  logic [3:0]  TX_DATA;

  modport master (
    output send, nbytes, data,
    input  ready, addr, TX_EN, TX_DATA
  );

  modport slave (
    input  send, nbytes, data,
    output ready, addr, TX_EN, TX_DATA
  );
endinterface

// File: rtl/iob_eth_tx.sv
// MII (4-bit) Ethernet transmitter: preamble/SFD, buffer bytes, optional pad, CRC-32 FCS, IFG.
// Optional ETH_TX_PAD_EN: zero-pad frames shorter than 60 bytes up to the Ethernet minimum.
module iob_eth_tx #(
  parameter int IFG_NIBBLES = 24,
  parameter int MAX_PAYLOAD = 1500
) (
  input  logic        TX_CLK,
  input  logic        rst,
  iob_eth_tx_if.slave bus
);
  localparam logic [10:0] HDR_LEN  = 11'd14;
  localparam logic [10:0] MAX_PL   = 11'(MAX_PAYLOAD);
  localparam logic [11:0] IFG_LAST = 12'(IFG_NIBBLES - 1);
`ifdef ETH_TX_PAD_EN
  localparam logic [10:0] MIN_LEN  = 11'd60;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_FCS,
    S_IFG
`ifdef ETH_TX_PAD_EN
    , S_PAD
`endif
  } state_t;

  state_t      state_reg, state_next;
  logic [11:0] cnt_reg, cnt_next;
  logic [10:0] byte_reg, byte_next;
  logic        phase_reg, phase_next;
  logic [10:0] len_reg, len_next;
  logic [3:0]  hi_reg, hi_next;
  logic [31:0] crc_reg, crc_next;
  logic        ready_reg, ready_next;
  logic [10:0] addr_reg, addr_next;
  logic        tx_en_reg, tx_en_next;
  logic [3:0]  tx_data_reg, tx_data_next;

  logic        start_byte;
  logic [10:0] byte_idx;
  logic [10:0] nb_clamped;
  logic [10:0] last_idx;
  logic [31:0] crc_inv;
  logic [2:0]  fcs_sel;

  // Reflected CRC-32 (poly 0x04C11DB7), one byte per call, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign nb_clamped = (bus.nbytes > MAX_PL) ? MAX_PL : bus.nbytes;
  assign last_idx   = len_reg - 11'd1;
  assign crc_inv    = ~crc_reg;
  assign fcs_sel    = cnt_reg[2:0] + 3'd1;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    byte_next    = byte_reg;
    phase_next   = phase_reg;
    len_next     = len_reg;
    hi_next      = hi_reg;
    crc_next     = crc_reg;
    ready_next   = ready_reg;
    addr_next    = addr_reg;
    tx_en_next   = tx_en_reg;
    tx_data_next = tx_data_reg;
    start_byte   = 1'b0;
    byte_idx     = '0;

    case (state_reg)
      S_IDLE: begin
        ready_next   = 1'b1;
        tx_en_next   = 1'b0;
        tx_data_next = 4'h0;
        addr_next    = '0;
        crc_next     = 32'hFFFFFFFF;
        if (bus.send) begin
          state_next   = S_PRE;
          len_next     = HDR_LEN + nb_clamped;
          cnt_next     = '0;
          ready_next   = 1'b0;
          tx_en_next   = 1'b1;
          tx_data_next = 4'h5;
        end
      end
      S_PRE: begin
        cnt_next = cnt_reg + 12'd1;
        if (cnt_reg == 12'd14) begin
          tx_data_next = 4'hD;
        end else if (cnt_reg == 12'd15) begin
          start_byte = 1'b1;
          byte_idx   = '0;
        end
      end
      S_DATA: begin
        if (!phase_reg) begin
          tx_data_next = hi_reg;
          phase_next   = 1'b1;
        end else if (byte_reg != last_idx) begin
          start_byte = 1'b1;
          byte_idx   = byte_reg + 11'd1;
        end else begin
`ifdef ETH_TX_PAD_EN
          if (len_reg < MIN_LEN) begin
            state_next   = S_PAD;
            byte_next    = len_reg;
            phase_next   = 1'b0;
            tx_data_next = 4'h0;
            crc_next     = crc_byte(crc_reg, 8'h00);
          end else begin
            state_next   = S_FCS;
            cnt_next     = '0;
            tx_data_next = crc_inv[3:0];
          end
`else
          state_next   = S_FCS;
          cnt_next     = '0;
          tx_data_next = crc_inv[3:0];
`endif
        end
      end
`ifdef ETH_TX_PAD_EN
      S_PAD: begin
        tx_data_next = 4'h0;
        if (!phase_reg) begin
          phase_next = 1'b1;
        end else if (byte_reg != MIN_LEN - 11'd1) begin
          byte_next  = byte_reg + 11'd1;
          phase_next = 1'b0;
          crc_next   = crc_byte(crc_reg, 8'h00);
        end else begin
          state_next   = S_FCS;
          cnt_next     = '0;
          tx_data_next = crc_inv[3:0];
        end
      end
`endif
      S_FCS: begin
        if (cnt_reg == 12'd7) begin
          state_next   = S_IFG;
          cnt_next     = '0;
          tx_en_next   = 1'b0;
          tx_data_next = 4'h0;
        end else begin
          cnt_next     = cnt_reg + 12'd1;
          tx_data_next = crc_inv[{fcs_sel, 2'b00} +: 4];
        end
      end
      S_IFG: begin
        if (cnt_reg == IFG_LAST) begin
          state_next = S_IDLE;
          ready_next = 1'b1;
          addr_next  = '0;
          crc_next   = 32'hFFFFFFFF;
        end else begin
          cnt_next = cnt_reg + 12'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Byte k is on the RAM output at the edge starting its low nibble; prefetch k+1.
    if (start_byte) begin
      state_next   = S_DATA;
      byte_next    = byte_idx;
      phase_next   = 1'b0;
      tx_data_next = bus.data[3:0];
      hi_next      = bus.data[7:4];
      crc_next     = crc_byte(crc_reg, bus.data);
      addr_next    = (byte_idx == last_idx) ? last_idx : byte_idx + 11'd1;
    end
  end

  always_ff @(posedge TX_CLK or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      byte_reg    <= '0;
      phase_reg   <= 1'b0;
      len_reg     <= '0;
      hi_reg      <= '0;
      crc_reg     <= 32'hFFFFFFFF;
      ready_reg   <= 1'b1;
      addr_reg    <= '0;
      tx_en_reg   <= 1'b0;
      tx_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      byte_reg    <= byte_next;
      phase_reg   <= phase_next;
      len_reg     <= len_next;
      hi_reg      <= hi_next;
      crc_reg     <= crc_next;
      ready_reg   <= ready_next;
      addr_reg    <= addr_next;
      tx_en_reg   <= tx_en_next;
      tx_data_reg <= tx_data_next;
    end
  end

  assign bus.ready   = ready_reg;
  assign bus.addr    = addr_reg;
  assign bus.TX_EN   = tx_en_reg;
  assign bus.TX_DATA = tx_data_reg;
endmodule

// File: tb/tb_iob_eth_tx.sv
// Self-checking bench for iob_eth_tx: table vectors, random frames against a byte-level
// frame model, plus hand-written sequences for back-to-back sends and mid-frame reset.
`timescale 1ns/1ps
module tb_iob_eth_tx;
  localparam int IFG  = 24;
  localparam int MAXP = 1500;

  logic TX_CLK = 1'b0;
  logic rst    = 1'b0;
  iob_eth_tx_if bus();

  iob_eth_tx #(.IFG_NIBBLES(IFG), .MAX_PAYLOAD(MAXP)) dut (
    .TX_CLK(TX_CLK),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 TX_CLK = ~TX_CLK;

  // TX buffer RAM with registered read
  logic [7:0] mem [0:2047];
  always @(posedge TX_CLK) bus.data <= mem[bus.addr];

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_bytes[$];
  logic [3:0] exp_nib[$];
  logic [3:0] got_nib[$];
  int model_en, model_max;

  typedef struct {
    int nb;
    int en;
    int maxa;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  // Bit-serial CRC-32 as defined for Ethernet: bits in wire order, reflected poly.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic build_model(input int nb);
    int pl, l, lp;
    logic [31:0] crc, fcs;
    pl = (nb > MAXP) ? MAXP : nb;
    l  = 14 + pl;
    lp = l;
`ifdef ETH_TX_PAD_EN
    if (lp < 60) lp = 60;
`endif
    exp_bytes.delete();
    for (int k = 0; k < lp; k++) exp_bytes.push_back((k < l) ? mem[k] : 8'h00);
    crc = 32'hFFFFFFFF;
    foreach (exp_bytes[i]) crc = crc_upd(crc, exp_bytes[i]);
    fcs = ~crc;
    exp_nib.delete();
    for (int i = 0; i < 15; i++) exp_nib.push_back(4'h5);
    exp_nib.push_back(4'hD);
    foreach (exp_bytes[i]) begin
      exp_nib.push_back(exp_bytes[i][3:0]);
      exp_nib.push_back(exp_bytes[i][7:4]);
    end
    for (int i = 0; i < 8; i++) exp_nib.push_back(fcs[4*i +: 4]);
    model_en  = 16 + 2 * lp + 8;
    model_max = l - 1;
  endtask

  // Starts and checks one frame; called at a negedge, returns at a negedge with ready=1.
  task automatic run_frame(input int nb, input int exp_en, input int exp_max);
    int guard, en_cnt, gap, idle_bad, maxa, mism, n;
    bit done;
    logic [31:0] res, rev;
    logic [7:0] b;
    build_model(nb);
    if (exp_en < 0) exp_en = model_en;
    if (exp_max < 0) exp_max = model_max;
    guard = 0;
    while (bus.ready !== 1'b1 && guard < 5000) begin
      @(negedge TX_CLK);
      guard++;
    end
    chk("ready_before_send", bus.ready, 1);
    bus.send   = 1'b1;
    bus.nbytes = nb[10:0];
    @(negedge TX_CLK);
    bus.send = 1'b0;
    chk("ready_low_after_accept", bus.ready, 0);
    got_nib.delete();
    en_cnt = 0; gap = 0; idle_bad = 0; maxa = 0; done = 0;
    for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
      if (bus.ready === 1'b1) begin
        done = 1;
      end else begin
        if (bus.TX_EN === 1'b1) begin
          got_nib.push_back(bus.TX_DATA);
          en_cnt++;
        end else begin
          gap++;
          if (bus.TX_DATA !== 4'h0) idle_bad++;
        end
        if (int'(bus.addr) > maxa) maxa = int'(bus.addr);
        @(negedge TX_CLK);
      end
    end
    chk("frame_done", done, 1);
    chk("tx_en_cycles", en_cnt, exp_en);
    chk("ifg_cycles", gap, IFG);
    chk("idle_txdata_zero", idle_bad, 0);
    chk("max_addr", maxa, exp_max);
    mism = (got_nib.size() > exp_nib.size()) ? got_nib.size() - exp_nib.size()
                                             : exp_nib.size() - got_nib.size();
    for (int i = 0; i < got_nib.size() && i < exp_nib.size(); i++)
      if (got_nib[i] !== exp_nib[i]) mism++;
    chk("nibble_stream_mismatches", mism, 0);
    // Receiver-side residue over frame bytes plus the FCS actually transmitted
    res = 32'hFFFFFFFF;
    foreach (exp_bytes[i]) res = crc_upd(res, exp_bytes[i]);
    n = got_nib.size();
    if (n >= 8) begin
      for (int j = 0; j < 4; j++) begin
        b = {got_nib[n - 8 + 2*j + 1], got_nib[n - 8 + 2*j]};
        res = crc_upd(res, b);
      end
    end
    for (int i = 0; i < 32; i++) rev[i] = res[31 - i];
    chk("fcs_residue", rev, 32'hC704DD7B);
    $display("frame nbytes=%0d tx_en_cycles=%0d/%0d ifg=%0d max_addr=%0d nibble_diffs=%0d residue=%08h",
             nb, en_cnt, exp_en, gap, maxa, mism, rev);
  endtask

  initial begin
    int starts, falls, fall_cyc, rise_cyc, bad, en_samples, l;
    bit prev;

    bus.send   = 1'b0;
    bus.nbytes = '0;
    for (int k = 0; k < 2048; k++) mem[k] = k[7:0];

`ifdef ETH_TX_PAD_EN
    vecs[0] = '{nb: 0,    en: 144,  maxa: 13};
    vecs[1] = '{nb: 45,   en: 144,  maxa: 58};
`else
    vecs[0] = '{nb: 0,    en: 52,   maxa: 13};
    vecs[1] = '{nb: 45,   en: 142,  maxa: 58};
`endif
    vecs[2] = '{nb: 46,   en: 144,  maxa: 59};
    vecs[3] = '{nb: 100,  en: 252,  maxa: 113};
    vecs[4] = '{nb: 1500, en: 3052, maxa: 1513};
    vecs[5] = '{nb: 2047, en: 3052, maxa: 1513};

    // Async reset takes effect before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("reset_ready", bus.ready, 1);
    chk("reset_tx_en", bus.TX_EN, 0);
    chk("reset_tx_data", bus.TX_DATA, 0);
    chk("reset_addr", bus.addr, 0);
    #20;
    @(negedge TX_CLK);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge TX_CLK);
      if (bus.TX_EN !== 1'b0 || bus.TX_DATA !== 4'h0 || bus.ready !== 1'b1 || bus.addr !== 11'd0)
        bad++;
    end
    chk("idle_100_cycles", bad, 0);
    $display("reset idle window: %0d active cycles", bad);

    foreach (vecs[i]) run_frame(vecs[i].nb, vecs[i].en, vecs[i].maxa);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 2048; k++) mem[k] = 8'($urandom);
      run_frame(int'($urandom_range(0, 120)), -1, -1);
    end

    // send held high: second frame starts IFG+1 cycles after TX_EN falls
    bus.nbytes = 11'd0;
    bus.send   = 1'b1;
    starts = 0; falls = 0; fall_cyc = 0; rise_cyc = 0; prev = 1'b0;
    for (int c = 0; c < 600 && starts < 2; c++) begin
      @(negedge TX_CLK);
      if (bus.TX_EN === 1'b1 && !prev) begin
        starts++;
        if (starts == 2) rise_cyc = c;
      end
      if (bus.TX_EN === 1'b0 && prev && falls == 0) begin
        fall_cyc = c;
        falls++;
      end
      prev = (bus.TX_EN === 1'b1);
    end
    bus.send = 1'b0;
    chk("held_send_two_frames", starts, 2);
    chk("held_send_rise_after_fall", rise_cyc - fall_cyc, IFG + 1);
    $display("held send: frames=%0d rise-fall=%0d", starts, rise_cyc - fall_cyc);
    for (int c = 0; c < 1000 && bus.ready !== 1'b1; c++) @(negedge TX_CLK);
    chk("held_send_ready", bus.ready, 1);

    // send pulses while busy are dropped
    bus.send = 1'b1;
    starts = 0; prev = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge TX_CLK);
      if (bus.TX_EN === 1'b1 && !prev) starts++;
      prev = (bus.TX_EN === 1'b1);
      bus.send = (c == 10 || c == 30 || c == 45);
    end
    bus.send = 1'b0;
    chk("busy_pulses_frame_count", starts, 1);
    chk("busy_pulses_ready", bus.ready, 1);
    $display("busy pulses: frames=%0d", starts);

    // Reset during payload byte 20 (buffer byte 34), then a clean frame
    for (int k = 0; k < 2048; k++) mem[k] = k[7:0];
    bus.nbytes = 11'd46;
    bus.send   = 1'b1;
    @(negedge TX_CLK);
    bus.send = 1'b0;
    en_samples = 0;
    l = 16 + 2 * 34 + 1;
    for (int c = 0; c < 400 && en_samples < l; c++) begin
      if (bus.TX_EN === 1'b1) en_samples++;
      if (en_samples < l) @(negedge TX_CLK);
    end
    chk("midframe_reached_byte", en_samples, l);
    #2 rst = 1'b1;
    #1;
    chk("midframe_rst_tx_en", bus.TX_EN, 0);
    chk("midframe_rst_tx_data", bus.TX_DATA, 0);
    chk("midframe_rst_ready", bus.ready, 1);
    @(negedge TX_CLK);
    @(negedge TX_CLK);
    rst = 1'b0;
    @(negedge TX_CLK);
    chk("after_rst_ready", bus.ready, 1);
    chk("after_rst_tx_en", bus.TX_EN, 0);
    $display("mid-frame reset at nibble %0d", en_samples);
    run_frame(46, 144, 59);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
